register_bank_16x32: RTL
========================

# register_bank_16x32

General-purpose register bank of the datapath: sixteen WIDTH-bit registers written and read through one-hot select vectors. It sits directly downstream of the 4-to-16 select decoders. One decoder instance drives the write-select vector and a second drives the read-select vector. The bank captures bus data into the selected register, returns the selected register onto the bus one cycle later, and flags malformed select vectors.

## Interface
Parameters:
- WIDTH, 32, data width of each register and of the bus ports
- BA_ZERO, 1, when 1, R0 reads as zero while ba_out is asserted (base-address mode)

Ports:
- clock  input  1  single system clock; all state updates on rising edge
- clear  input  1  synchronous, active-high reset
- wr_sel  input  16  one-hot write select from the write-side 4-to-16 decoder; bit i selects Ri
- rin  input  1  write strobe; write happens only when this is 1
- rd_sel  input  16  one-hot read select from the read-side 4-to-16 decoder
- rout  input  1  read strobe
- ba_out  input  1  base-address read mode for R0
- bus_in  input  WIDTH  write data
- bus_out  output  WIDTH  registered read data
- bus_out_valid  output  1  high for one cycle when bus_out holds a fresh read result
- sel_error  output  1  one-cycle pulse flagging an invalid select vector

Reset is synchronous and active-high on clear; there is one clock.

## Operation
- Storage: R0..R15, each WIDTH bits.
- Valid select: a select vector is valid only when exactly one bit is set. All-zero and multi-bit vectors are invalid.
- Write: at a rising edge with clear=0, rin=1 and wr_sel valid, R[idx(wr_sel)] <= bus_in.
  - With rin=0, wr_sel is ignored and no error is raised.
- Read: at a rising edge with clear=0, rout=1 and rd_sel valid:
  - bus_out <= R[idx(rd_sel)]; bus_out_valid <= 1.
- Read of R0: if BA_ZERO=1 and ba_out=1, the read returns 0 whatever R0 holds.
  - Writes to R0 are always stored normally; ba_out affects reads only.
- Same-cycle write and read of the same register: write-first bypass. bus_out takes the new bus_in value.
  - The ba_out rule for R0 still overrides the bypass.
- No read, or invalid read: bus_out holds its previous value and bus_out_valid <= 0.
- Errors: sel_error <= 1 for one cycle if (rin=1 and wr_sel invalid) or (rout=1 and rd_sel invalid).
  - An invalid write leaves every register unchanged.
  - An invalid read leaves bus_out unchanged.
  - A valid access on the other port in the same cycle still completes.
- Reset: clear=1 at a rising edge takes priority over all other inputs.
  - R0..R15 become 0; bus_out = 0, bus_out_valid = 0, sel_error = 0.
  - Any read or write presented in the same cycle is discarded.

## Timing
- Write latency: 1 edge. Data is visible to a read issued on the following cycle.
- Read latency: 1 cycle. bus_out and bus_out_valid update at the edge that samples rout.
- Throughput: one write and one read accepted every cycle, back-to-back, with no stall.
- No handshake back-pressure: strobes are single-cycle commands, and holding rout high re-reads every cycle.
- sel_error is registered, asserting the cycle after the offending request; it never stays high more than one cycle per offending request.
- Reset mid-operation: a read issued the cycle before clear still completes at its own edge. The clear edge then zeroes bus_out and bus_out_valid.
- All outputs are driven directly from flops; there is no combinational path from inputs to outputs.

## Test plan
- Reset: drive clear=1 for one edge after random writes, then read R0..R15 -> every read returns 0x00000000 with bus_out_valid=1 one cycle after each rout.
- Write/read sweep: write 0xA5A50000+i into Ri for i=0..15 (wr_sel=1<<i, rin=1), then read each back -> bus_out=0xA5A50000+i one cycle after each read, no sel_error.
- Bypass: in the same cycle, rin=1, rout=1, wr_sel=rd_sel=16'h0020, bus_in=0xDEADBEEF, with R5 previously 0x1 -> next cycle bus_out=0xDEADBEEF.
- Base-address mode: write 0x12345678 to R0, read with ba_out=1 -> bus_out=0; read again with ba_out=0 -> bus_out=0x12345678.
- Invalid selects:
  - rin=1 with wr_sel=16'h0003 -> sel_error=1 for exactly one cycle; R0 and R1 unchanged.
  - rout=1 with rd_sel=16'h0000 -> sel_error=1, bus_out_valid=0, bus_out unchanged.
- Clear priority: clear=1 with rin=1, wr_sel=16'h8000, bus_in=0xFFFFFFFF -> next cycle read of R15 returns 0; bus_out_valid=0 in the clear cycle.

Source files
------------

// File: rtl/register_bank_16x32.sv
// Sixteen WIDTH-bit registers behind one-hot write/read selects, with select-error flag.
// Latency: write visible next cycle; read data/valid registered one cycle after rout.
// Backpressure: none; one write and one read accepted every cycle, strobes are commands.
module register_bank_16x32 #(
  parameter int WIDTH   = 32,
  parameter int BA_ZERO = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [15:0]      wr_sel,
  input  logic             rin,
  input  logic [15:0]      rd_sel,
  input  logic             rout,
  input  logic             ba_out,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_out_valid,
  output logic             sel_error
);

  // A select is usable only when exactly one bit is set.
  function automatic logic is_onehot(input logic [15:0] v);
    return (v != 16'h0000) && ((v & (v - 16'd1)) == 16'h0000);
  endfunction

  // Index of the set bit; only meaningful for a one-hot vector.
  function automatic logic [3:0] sel_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

  logic [WIDTH-1:0] regs_q [16];
  logic [WIDTH-1:0] regs_d [16];
  logic [WIDTH-1:0] bus_out_q, bus_out_d;
  logic             valid_q, valid_d;
  logic             sel_error_q, sel_error_d;

  logic             wr_ok, rd_ok;
  logic             wr_en, rd_en;
  logic [3:0]       wr_idx, rd_idx;
  logic [WIDTH-1:0] rd_data;
  logic             rd_masked;

  // Decode both select vectors and qualify them with their strobes.
  always_comb begin
    wr_ok     = is_onehot(wr_sel);
    rd_ok     = is_onehot(rd_sel);
    wr_idx    = sel_index(wr_sel);
    rd_idx    = sel_index(rd_sel);
    wr_en     = rin & wr_ok;
    rd_en     = rout & rd_ok;
    rd_masked = (BA_ZERO != 0) && ba_out && (rd_idx == 4'd0);
  end

  // Next register contents: only a valid, strobed write changes storage.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_idx] = bus_in;
    end
  end

  // Read data: base-address masking of R0 wins, then write-first bypass, then storage.
  always_comb begin
    rd_data = regs_q[rd_idx];
    if (rd_masked) begin
      rd_data = '0;
    end else if (wr_en && (wr_idx == rd_idx)) begin
      rd_data = bus_in;
    end
  end

  // Output next-state: bus_out holds on no/invalid read; error on any malformed strobed select.
  always_comb begin
    bus_out_d   = bus_out_q;
    valid_d     = 1'b0;
    sel_error_d = (rin & ~wr_ok) | (rout & ~rd_ok);
    if (rd_en) begin
      bus_out_d = rd_data;
      valid_d   = 1'b1;
    end
  end

  // State update; clear discards any access presented in the same cycle.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
      bus_out_q   <= '0;
      valid_q     <= 1'b0;
      sel_error_q <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= regs_d[i];
      end
      bus_out_q   <= bus_out_d;
      valid_q     <= valid_d;
      sel_error_q <= sel_error_d;
    end
  end

  assign bus_out       = bus_out_q;
  assign bus_out_valid = valid_q;
  assign sel_error     = sel_error_q;

endmodule
